aes_key_sched_ctrl: RTL

Sequential key-schedule controller for AES-128. It accepts a 128-bit cipher key over a valid/ready handshake. It then iterates one shared instance of aes_key_expand_128 once per clock for 10 rounds and stores all 11 round keys in an internal register file. A registered random-access read port serves round keys to the encrypt/decrypt round datapath in the UART AES designs.

---
 rtl/aes_key_sched_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: expands one cipher key over 10 cycles into an
// 11-entry round-key store with a registered read port. Define AES_KS_DEC_ORDER_EN to mirror read addresses.
module aes_key_expand_128 (
    input  logic [127:0] key_in,
    input  logic [3:0]   select_i,
    output logic [127:0] key_out
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254, with 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)), gf_mul(gf_mul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]  rcon;
    logic [31:0] temp;
    logic [31:0] w0, w1, w2, w3;

    always_comb begin
        rcon = 8'h00;
        case (select_i)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // SubWord(RotWord(w3)) xor Rcon
    assign temp = {sbox(key_in[23:16]) ^ rcon, sbox(key_in[15:8]),
                   sbox(key_in[7:0]), sbox(key_in[31:24])};
    assign w0 = key_in[127:96] ^ temp;
    assign w1 = key_in[95:64] ^ w0;
    assign w2 = key_in[63:32] ^ w1;
    assign w3 = key_in[31:0] ^ w2;
    assign key_out = {w0, w1, w2, w3};
endmodule

module aes_key_sched_ctrl #(
    parameter int NR = 10,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [127:0]  key_in,
    input  logic          key_valid,
    output logic          key_ready,
    output logic          busy,
    output logic          done,
    output logic          keys_valid,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [127:0]  rd_data,
    output logic          rd_valid
);
    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [3:0]    LAST    = 4'(NR);
    localparam logic [AW-1:0] MAX_IDX = AW'(NR);

    state_t        state_reg, state_next;
    logic          armed_reg;
    logic [3:0]    rnd_reg;
    logic [127:0]  cur_reg;
    logic          keys_valid_reg;
    logic          done_reg;
    logic [127:0]  rd_data_reg;
    logic          rd_valid_reg;
    logic [127:0]  rk_reg [0:NR];
    logic [127:0]  key_out;
    logic [3:0]    sel;
    logic          accept;
    logic          last_rnd;
    logic [AW-1:0] rd_idx;
    logic          rd_hit;

    // armed_reg keeps key_ready low while reset is asserted and until the first clock after release.
    assign key_ready = armed_reg && (state_reg == IDLE);
    assign busy      = (state_reg == EXPAND);
    assign done      = done_reg;
    assign keys_valid = keys_valid_reg;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;

    assign accept   = key_valid && key_ready;
    assign last_rnd = (state_reg == EXPAND) && (rnd_reg == LAST);
    assign sel      = rnd_reg - 4'd1;

    aes_key_expand_128 u_expand (
        .key_in   (cur_reg),
        .select_i (sel),
        .key_out  (key_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXPAND;
            EXPAND:  if (last_rnd) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_reg      <= 1'b0;
            rnd_reg        <= 4'd0;
            cur_reg        <= '0;
            keys_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            done_reg  <= last_rnd;
            if (accept) begin
                cur_reg        <= key_in;
                rnd_reg        <= 4'd1;
                keys_valid_reg <= 1'b0;
            end else if (state_reg == EXPAND) begin
                cur_reg <= key_out;
                rnd_reg <= rnd_reg + 4'd1;
                if (last_rnd) keys_valid_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi <= NR; gi++) begin : g_store
            localparam logic [3:0] IDX = 4'(gi);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rk_reg[gi] <= '0;
                end else if (gi == 0) begin
                    if (accept) rk_reg[gi] <= key_in;
                end else if (state_reg == EXPAND && rnd_reg == IDX) begin
                    rk_reg[gi] <= key_out;
                end
            end
        end
    endgenerate

`ifdef AES_KS_DEC_ORDER_EN
    assign rd_idx = MAX_IDX - rd_addr;
`else
    assign rd_idx = rd_addr;
`endif
    assign rd_hit = rd_en && keys_valid_reg && (rd_addr <= MAX_IDX);

    // Reads sample keys_valid_reg before any same-edge accept, so they see the old store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en && keys_valid_reg;
            rd_data_reg  <= rd_hit ? rk_reg[rd_idx] : '0;
        end
    end
endmodule
